// File: rtl/data_decoder_pkg.sv
// Shared definitions for the Maple bus receive-side decoder.
package data_decoder_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_WAIT_A = 5'b00010,
    ST_WAIT_B = 5'b00100,
    ST_DONE   = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  localparam logic BUS_IDLE             = 1'b1;
  localparam int   IDLE_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/data_decoder_line_sync.sv
// Bus line synchronizer chain followed by a falling-edge detector.
module maple_line_sync
  import data_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= {SYNC_STAGES{BUS_IDLE}};
      prev  <= BUS_IDLE;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign fall = prev & ~q;

endmodule

// File: rtl/data_decoder.sv
// Maple bus bit engine: recovers MSB-first bytes from sdcka/sdckb and pushes them to the rx FIFO.
//
// state   | meaning
// IDLE    | disarmed, waiting for enable
// WAIT_A  | expecting sdcka fall (sdckb carries the bit)
// WAIT_B  | expecting sdckb fall (sdcka carries the bit)
// DONE    | one-cycle done pulse, frame ended on a byte boundary
// ERROR   | one-cycle error pulse, protocol violation or overflow
module data_decoder
  import data_decoder_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT,
  parameter int TW           = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sdcka,
  input  logic       sdckb,
  input  logic       full,
  output logic [7:0] data,
  output logic       push,
  output logic       done,
  output logic       error,
  output logic       busy
);

  localparam logic [TW-1:0] TMO_MAX = TW'(IDLE_TIMEOUT);

  logic          a_q, a_fall, b_q, b_fall;
  state_t        state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] tmo;
  logic          pend;
  logic          byte_seen;
  logic          tmo_hit;

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk), .reset (reset), .d (sdcka), .q (a_q), .fall (a_fall)
  );

  maple_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk), .reset (reset), .d (sdckb), .q (b_q), .fall (b_fall)
  );

  assign tmo_hit = (tmo == TMO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      tmo       <= '0;
      pend      <= 1'b0;
      byte_seen <= 1'b0;
      data      <= '0;
      push      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      push  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      pend  <= 1'b0;

      // A completed byte is delivered even if the frame is being abandoned this cycle.
      if (pend && !full) begin
        push      <= 1'b1;
        data      <= shift_reg;
        byte_seen <= 1'b1;
      end

      if (state != ST_IDLE && !enable) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (pend && full) begin
        state <= ST_ERROR;
        error <= 1'b1;
        busy  <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable) begin
              state     <= ST_WAIT_A;
              busy      <= 1'b1;
              bit_cnt   <= '0;
              tmo       <= '0;
              byte_seen <= 1'b0;
            end
          end
          ST_WAIT_A: begin
            if (b_fall) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if (a_fall) begin
              shift_reg <= {shift_reg[6:0], b_q};
              bit_cnt   <= bit_cnt + 3'd1;
              pend      <= (bit_cnt == 3'd7);
              tmo       <= '0;
              state     <= ST_WAIT_B;
            end else if (tmo_hit) begin
              // An empty frame keeps waiting; only a received byte makes a clean end.
              if (bit_cnt != 3'd0) begin
                state <= ST_ERROR;
                error <= 1'b1;
              end else if (byte_seen) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          ST_WAIT_B: begin
            if (a_fall) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else if (b_fall) begin
              shift_reg <= {shift_reg[6:0], a_q};
              bit_cnt   <= bit_cnt + 3'd1;
              pend      <= (bit_cnt == 3'd7);
              tmo       <= '0;
              state     <= ST_WAIT_A;
            end else if (tmo_hit) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          ST_DONE, ST_ERROR: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_data_decoder.sv
// Directed bench for data_decoder: encoder-shaped bus waveforms with hand-computed results.
module tb_data_decoder;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sdcka;
  logic       sdckb;
  logic       full;
  logic [7:0] data;
  logic       push;
  logic       done;
  logic       error;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int         push_n = 0;
  int         done_n = 0;
  int         err_n  = 0;
  logic [7:0] got_bytes[$];

  data_decoder dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .sdcka  (sdcka),
    .sdckb  (sdckb),
    .full   (full),
    .data   (data),
    .push   (push),
    .done   (done),
    .error  (error),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (push) begin
      push_n++;
      got_bytes.push_back(data);
    end
    if (done)  done_n++;
    if (error) err_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_at(input int i);
    if (i < got_bytes.size()) return got_bytes[i];
    return 8'h00;
  endfunction

  task automatic bit_a(input logic b);
    sdcka = 1'b1; sdckb = b;
    tick(2);
    sdcka = 1'b0;
    tick(2);
  endtask

  task automatic bit_b(input logic b);
    sdckb = 1'b1; sdcka = b;
    tick(2);
    sdckb = 1'b0;
    tick(2);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) bit_a(v[7-i]);
      else            bit_b(v[7-i]);
    end
  endtask

  // Park line B low before arming so the first phase-1 bit never looks like a B fall.
  task automatic start_frame();
    enable = 1'b0; full = 1'b0;
    sdcka = 1'b1; sdckb = 1'b1;
    tick(5);
    sdckb = 1'b0;
    tick(5);
    enable = 1'b1;
    tick(2);
  endtask

  task automatic wait_done(input int start, input int limit, output int cyc);
    cyc = 0;
    while (done_n == start && cyc < limit) begin
      tick(1);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, d0, e0, cyc;

    reset = 1'b0; enable = 1'b0; full = 1'b0;
    sdcka = 1'b1; sdckb = 1'b1;
    tick(3);
    check("rst_push",  push,  1'b0);
    check("rst_data",  data,  8'h00);
    check("rst_done",  done,  1'b0);
    check("rst_error", error, 1'b0);
    check("rst_busy",  busy,  1'b0);
    reset = 1'b1;
    tick(2);

    // Single byte 0xA5 followed by bus quiet
    start_frame();
    check("armed_busy", busy, 1'b1);
    p0 = push_n; d0 = done_n; e0 = err_n;
    send_bits(8'hA5, 8);
    sdcka = 1'b1; sdckb = 1'b1;
    wait_done(d0, 60, cyc);
    check("a5_push_cnt", push_n - p0, 1);
    check("a5_data",     byte_at(p0), 8'hA5);
    check("a5_done_cnt", done_n - d0, 1);
    check("a5_err_cnt",  err_n - e0, 0);
    check("a5_done_delay_ge16", (cyc >= 16), 1'b1);

    // Back-to-back bytes
    start_frame();
    p0 = push_n; d0 = done_n; e0 = err_n;
    send_bits(8'h00, 8);
    send_bits(8'hFF, 8);
    send_bits(8'h3C, 8);
    sdcka = 1'b1; sdckb = 1'b1;
    wait_done(d0, 80, cyc);
    check("b2b_push_cnt", push_n - p0, 3);
    check("b2b_byte0",    byte_at(p0),     8'h00);
    check("b2b_byte1",    byte_at(p0 + 1), 8'hFF);
    check("b2b_byte2",    byte_at(p0 + 2), 8'h3C);
    check("b2b_done_cnt", done_n - d0, 1);
    check("b2b_err_cnt",  err_n - e0, 0);

    // Line B falls while expecting A
    start_frame();
    p0 = push_n; d0 = done_n; e0 = err_n;
    sdckb = 1'b1;
    tick(3);
    sdckb = 1'b0;
    tick(6);
    check("bfirst_err_cnt",  err_n - e0, 1);
    check("bfirst_push_cnt", push_n - p0, 0);
    check("bfirst_done_cnt", done_n - d0, 0);

    // Stall mid-byte after 5 bits of 0xC3
    start_frame();
    p0 = push_n; d0 = done_n; e0 = err_n;
    send_bits(8'hC3, 5);
    tick(40);
    check("stall_err_cnt",  err_n - e0, 1);
    check("stall_push_cnt", push_n - p0, 0);
    check("stall_done_cnt", done_n - d0, 0);

    // FIFO full when the byte completes
    start_frame();
    p0 = push_n; d0 = done_n; e0 = err_n;
    full = 1'b1;
    send_bits(8'h81, 8);
    tick(5);
    full = 1'b0;
    check("ovf_err_cnt",  err_n - e0, 1);
    check("ovf_push_cnt", push_n - p0, 0);

    // Enable dropped mid-byte
    start_frame();
    p0 = push_n; d0 = done_n; e0 = err_n;
    send_bits(8'hA0, 3);
    tick(3);
    enable = 1'b0;
    tick(1);
    check("dis_busy",     busy, 1'b0);
    tick(4);
    check("dis_push_cnt", push_n - p0, 0);
    check("dis_done_cnt", done_n - d0, 0);
    check("dis_err_cnt",  err_n - e0, 0);

    // Async reset mid-byte, then a clean frame
    start_frame();
    send_bits(8'h96, 4);
    #1;
    reset = 1'b0;
    #1;
    check("arst_push",  push,  1'b0);
    check("arst_data",  data,  8'h00);
    check("arst_done",  done,  1'b0);
    check("arst_error", error, 1'b0);
    check("arst_busy",  busy,  1'b0);
    enable = 1'b0;
    tick(2);
    reset = 1'b1;
    start_frame();
    p0 = push_n; d0 = done_n; e0 = err_n;
    send_bits(8'h5A, 8);
    sdcka = 1'b1; sdckb = 1'b1;
    wait_done(d0, 60, cyc);
    check("post_rst_push_cnt", push_n - p0, 1);
    check("post_rst_data",     byte_at(p0), 8'h5A);
    check("post_rst_done_cnt", done_n - d0, 1);
    check("post_rst_err_cnt",  err_n - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_decoder.md
Name: data_decoder

Overview:
- Maple bus receive-side bit engine, the counterpart of the transmit encoder.
- Watches the two bus lines sdcka/sdckb and recovers bits MSB-first.
  - Phase 1: sdcka falls; sdckb is the data bit.
  - Phase 2: sdckb falls; sdcka is the data bit.
- Assembles bits into bytes and pushes each byte into the slave receive FIFO.
- Flags end-of-frame when the bus goes quiet, and flags protocol errors.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each bus line (minimum 2).
- IDLE_TIMEOUT, 16, clk cycles with no expected falling edge that end the frame.
- TW, 5, width of the timeout counter (must hold IDLE_TIMEOUT).

Ports:
- clk  input  1  system clock, same domain as the encoder.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  level; high arms and keeps the decoder receiving.
- sdcka  input  1  bus line A, asynchronous to clk.
- sdckb  input  1  bus line B, asynchronous to clk.
- full  input  1  receive FIFO full.
- data  output  8  assembled byte, valid while push is high.
- push  output  1  one-cycle FIFO write strobe.
- done  output  1  one-cycle pulse: frame ended cleanly on a byte boundary.
- error  output  1  one-cycle pulse: protocol violation or overflow.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-low):
  - State is IDLE; shift register, bit counter and timeout counter are 0.
  - data=0, push=0, done=0, error=0, busy=0.
  - Synchronizer flops reset to 1, the bus idle level.
- Input path:
  - Each line passes through an identical SYNC_STAGES chain, then one previous-value flop.
  - Falling edge = prev 1 and cur 0.
  - The data bit is the synchronized value of the other line in the same cycle the edge is detected. Equal chain delay preserves the encoder's one-cycle data-before-clock setup.
- States: IDLE, WAIT_A, WAIT_B, DONE, ERROR.
- IDLE:
  - Enable high → WAIT_A on the next clock; clear bit counter and timeout counter.
- WAIT_A (expecting a sdcka fall):
  - sdcka fall → shift sdckb in at the LSB (shift register shifts left), bit_cnt+1, timeout=0, → WAIT_B.
  - sdckb fall with no sdcka fall → ERROR.
  - Both fall in the same cycle → ERROR.
  - timeout reaches IDLE_TIMEOUT:
    - bit_cnt==0 → DONE, but only if at least one byte was received; otherwise stay in WAIT_A.
    - bit_cnt!=0 → ERROR.
- WAIT_B (expecting a sdckb fall):
  - Mirror of WAIT_A: sample sdcka on a sdckb fall, → WAIT_A.
  - sdcka fall, or both lines falling together → ERROR.
  - Timeout in WAIT_B → ERROR, since the byte is always mid-way.
- Byte completion:
  - When the 8th bit shifts in (bit_cnt wraps 7→0), on the next clock: push=1 for one cycle and data = the full byte.
  - First received bit is data[7].
  - If full is high at that moment → no push, error pulse, → ERROR; the byte is dropped.
- DONE and ERROR each last one cycle (done or error = 1), then → IDLE.
  - If enable is still high, the next frame arms on the following cycle.
- Enable low in any non-IDLE state:
  - → IDLE on the next clock; the partial byte is discarded.
  - No done or error pulse.
  - A push already scheduled for that cycle still occurs.
- Timeout counter:
  - Increments every cycle in WAIT_A and WAIT_B, clears on each accepted edge, and saturates.
- Reset asserted mid-frame: immediate return to the reset values above; no partial output.

Decomposition:
- Shared package holds:
  - the one-hot state encodings (same style as the encoder);
  - the bus idle level constant (1);
  - the default IDLE_TIMEOUT.
- One natural sub-module, maple_line_sync: the SYNC_STAGES synchronizer plus falling-edge detector.
  - Parameter: SYNC_STAGES.
  - Ports: clk, reset, d, q, fall.
  - Instantiated twice, once per line.

Test Plan:
- Encoder-shaped waveform for the single byte 0xA5, then idle: exactly one push with data=0xA5, then done 16+ cycles after the last sdckb fall; error stays 0.
- Back-to-back 0x00, 0xFF, 0x3C: three pushes in that order, one done at the end.
- Line B falls first while in WAIT_A after enable: error pulse, return to IDLE, no push.
- Stall after 5 bits of 0xC3 beyond IDLE_TIMEOUT: error pulse, no push, no done.
- full=1 when the 8th bit of 0x81 lands: no push, error pulse.
- Deassert enable after 3 bits: IDLE next cycle, no push/done/error. Async reset pulse mid-byte: all outputs 0 immediately, and the next full byte 0x5A decodes correctly.
